// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: one bit per clock, 33-cycle latency from
// start pulse to a one-cycle ready strobe, with registered result and exception flag.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Handshake: ctrl_MULT/ctrl_DIV are fire-and-forget start pulses accepted in any
  // state (a new start aborts the running operation); data_resultRDY is a one-cycle
  // valid strobe with no back-pressure, and data_result stays stable until the next completion.
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               fin;
  logic               neg;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               start;
  logic               iterating;
  logic               complete;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign iterating = (state == S_MUL) || (state == S_DIV);
  assign complete  = !start && iterating && fin;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? S_MUL : S_DIV;
    end else begin
      case (state)
        S_MUL, S_DIV: if (fin) state_nxt = S_DONE;
        S_DONE:       state_nxt = S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    in_mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    // Restoring divide: dividend bits shift out of acc[WIDTH-1] into the remainder.
    rem_shift = {rem, acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mag_b};
    prod      = neg ? -acc : acc;
    quot      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fin_res   = '0;
    fin_exc   = 1'b0;
    if (state == S_MUL) begin
      fin_res = prod[WIDTH-1:0];
      fin_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end else if (b_zero) begin
      fin_res = '0;
      fin_exc = 1'b1;
    end else begin
      fin_res = quot;
      // A positive quotient with the top bit set only arises from MIN / -1.
      fin_exc = !neg && acc[WIDTH-1];
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      fin    <= 1'b0;
      neg    <= 1'b0;
      b_zero <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
    end else if (start) begin
      cnt    <= '0;
      fin    <= 1'b0;
      neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      b_zero <= (data_operandB == '0);
      mag_a  <= in_mag_a;
      mag_b  <= in_mag_b;
      acc    <= {{WIDTH{1'b0}}, (ctrl_MULT ? in_mag_b : in_mag_a)};
      rem    <= '0;
    end else if (iterating && !fin) begin
      cnt <= cnt + CW'(1);
      fin <= (cnt == CW'(WIDTH - 1));
      if (state == S_MUL) begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
      end else if (!rem_diff[WIDTH]) begin
        rem             <= rem_diff[WIDTH-1:0];
        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
      end else begin
        rem             <= rem_shift[WIDTH-1:0];
        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= complete;
      busy           <= (state_nxt == S_MUL) || (state_nxt == S_DIV);
      if (complete) begin
        data_result    <= fin_res;
        data_exception <= fin_exc;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: vector table for arithmetic and latency,
// plus hand-written abort, result-hold and asynchronous-reset sequences.
module tb_multdiv_unit;

  logic        clock;
  logic        clr_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [1:0]  dbg_state;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .clr_n          (clr_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        mult;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t        vecs[12];
  logic [32:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          strobe_cnt = 0;
  logic [31:0] last_res = 32'h0;

  always @(negedge clock) if (data_resultRDY === 1'b1) strobe_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_rdy(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic scoreboard_pop(input string name);
    logic [32:0] e;
    e = exp_q.pop_front();
    chk({name, " result"}, data_result, e[31:0]);
    chk({name, " exception"}, 32'(data_exception), 32'(e[32]));
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    exp_q.push_back({v.exc, v.res});
    start_op(v.mult, v.div, v.a, v.b);
    chk({v.name, " busy"}, 32'(busy), 32'd1);
    wait_rdy(k);
    chk({v.name, " latency"}, k, 32'd33);
    scoreboard_pop(v.name);
    chk({v.name, " state done"}, 32'(dbg_state), 32'd3);
    @(posedge clock);
    #1;
    chk({v.name, " strobe low"}, 32'(data_resultRDY), 32'd0);
    chk({v.name, " busy low"}, 32'(busy), 32'd0);
    chk({v.name, " state idle"}, 32'(dbg_state), 32'd0);
    chk({v.name, " hold"}, data_result, v.res);
    last_res = v.res;
  endtask

  initial begin
    int k;
    int base;
    vecs[0]  = '{"mul 7*-6",        1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
    vecs[1]  = '{"mul 2^16*2^16",   1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[2]  = '{"mul min*1",       1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[3]  = '{"div -17/5",       1'b0, 1'b1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{"div 100/0",       1'b0, 1'b1, 32'd100,      32'd0,        32'h00000000, 1'b1};
    vecs[5]  = '{"div min/-1",      1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[6]  = '{"both 6,3",        1'b1, 1'b1, 32'd6,        32'd3,        32'd18,       1'b0};
    vecs[7]  = '{"mul -5*-7",       1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFF9, 32'd35,       1'b0};
    vecs[8]  = '{"div 7/-2",        1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{"mul maxpos*2",    1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    vecs[10] = '{"div -1/2",        1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000000, 1'b0};
    vecs[11] = '{"div 1000/-7",     1'b0, 1'b1, 32'd1000,     32'hFFFFFFF9, 32'hFFFFFF72, 1'b0};

    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    clr_n         = 1'b1;
    #2 clr_n = 1'b0;
    #5;
    chk("reset result", data_result, 32'h0);
    chk("reset exception", 32'(data_exception), 32'd0);
    chk("reset strobe", 32'(data_resultRDY), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    clr_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // abort: multiply restarted by a divide at cycle 10, result held across the restart
    base = strobe_cnt;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    exp_q.push_back({1'b0, 32'd5});
    start_op(1'b0, 1'b1, 32'd20, 32'd4);
    chk("abort hold result", data_result, last_res);
    chk("abort busy", 32'(busy), 32'd1);
    wait_rdy(k);
    chk("abort latency", k, 32'd33);
    scoreboard_pop("abort div");
    @(posedge clock);
    #1;
    chk("abort strobe count", strobe_cnt - base, 32'd1);

    // asynchronous reset in the middle of a divide
    start_op(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    #3 clr_n = 1'b0;
    #1;
    chk("async rst result", data_result, 32'h0);
    chk("async rst exception", 32'(data_exception), 32'd0);
    chk("async rst strobe", 32'(data_resultRDY), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst state", 32'(dbg_state), 32'd0);
    base = strobe_cnt;
    @(negedge clock);
    clr_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("async rst no strobe", strobe_cnt - base, 32'd0);
    run_vec('{"mul 2*2 after rst", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
